// File: rtl/spi_reg_bank_if.sv
// Byte-level link between the SPI slave byte engine and the register bank.
// The master drives chip select and received bytes; the bank returns tx data and write/frame strobes.
interface spi_reg_bank_if;
    logic       cs;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic       wr_pulse;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_done;
    logic       addr_err;

    modport master (
        output cs, rx_valid, rx_byte,
        input  tx_byte, wr_pulse, wr_addr, wr_data, frame_done, addr_err
    );

    modport slave (
        input  cs, rx_valid, rx_byte,
        output tx_byte, wr_pulse, wr_addr, wr_data, frame_done, addr_err
    );
endinterface

// File: rtl/spi_reg_bank.sv
// Command decoder and register file behind the SPI byte engine.
// Frame = command byte (bit7 read, [6:0] start address) followed by auto-incrementing data bytes.
//
//  state     | meaning
//  S_WAIT_CS | after reset: wait until cs is really seen high, so a frame is never joined mid-way
//  S_IDLE    | between frames, waiting for cs falling edge
//  S_CMD     | frame open, next byte is the command
//  S_WRITE   | data bytes are written to reg[addr++]
//  S_READ    | data bytes are dummies; tx_byte presents reg[addr++]
module spi_reg_bank #(
    parameter int         NUM_REGS   = 16,
    parameter logic [7:0] REG_INIT   = 8'h00,
    parameter logic [7:0] DUMMY_BYTE = 8'h00
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    spi_reg_bank_if.slave         bus,
    output logic [NUM_REGS*8-1:0] reg_flat
);
    localparam int         AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

    typedef enum logic [2:0] {S_WAIT_CS, S_IDLE, S_CMD, S_WRITE, S_READ} state_t;

    state_t     state;
    logic [7:0] regs [NUM_REGS];
    logic       cs_meta, cs_s, cs_s_d;
    logic [1:0] sync_cnt;
    logic [6:0] addr;
    logic [7:0] tx_byte_r;
    logic       wr_pulse_r;
    logic [6:0] wr_addr_r;
    logic [7:0] wr_data_r;
    logic       frame_done_r;
    logic       addr_err_r;

    logic       cs_fall, cs_rise, rx_acc;
    logic [6:0] addr_nxt;

    assign cs_fall  = cs_s_d & ~cs_s;
    assign cs_rise  = ~cs_s_d & cs_s;
    assign rx_acc   = bus.rx_valid & ~cs_s;
    assign addr_nxt = addr + 7'd1;

    function automatic logic in_range(input logic [6:0] a);
        return {1'b0, a} < NUM_REGS_B;
    endfunction

    function automatic logic [7:0] rd(input logic [6:0] a);
        return in_range(a) ? regs[a[AW-1:0]] : DUMMY_BYTE;
    endfunction

    // sync_cnt holds off S_WAIT_CS until cs_s reflects real samples rather than the reset preset
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state        <= S_WAIT_CS;
            cs_meta      <= 1'b1;
            cs_s         <= 1'b1;
            cs_s_d       <= 1'b1;
            sync_cnt     <= 2'd0;
            addr         <= 7'd0;
            tx_byte_r    <= DUMMY_BYTE;
            wr_pulse_r   <= 1'b0;
            wr_addr_r    <= 7'd0;
            wr_data_r    <= 8'd0;
            frame_done_r <= 1'b0;
            addr_err_r   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= REG_INIT;
        end else begin
            cs_meta      <= bus.cs;
            cs_s         <= cs_meta;
            cs_s_d       <= cs_s;
            wr_pulse_r   <= 1'b0;
            frame_done_r <= 1'b0;
            addr_err_r   <= 1'b0;
            if (sync_cnt != 2'd2) sync_cnt <= sync_cnt + 2'd1;

            case (state)
                S_WAIT_CS: begin
                    if (sync_cnt == 2'd2 && cs_s) state <= S_IDLE;
                end
                S_IDLE: begin
                    tx_byte_r <= DUMMY_BYTE;
                    if (cs_fall) state <= S_CMD;
                end
                default: begin
                    if (cs_rise) begin
                        state        <= S_IDLE;
                        frame_done_r <= 1'b1;
                        tx_byte_r    <= DUMMY_BYTE;
                    end else if (cs_fall) begin
                        state     <= S_CMD;
                        tx_byte_r <= DUMMY_BYTE;
                    end else if (rx_acc) begin
                        case (state)
                            S_CMD: begin
                                addr <= bus.rx_byte[6:0];
                                if (bus.rx_byte[7]) begin
                                    state     <= S_READ;
                                    tx_byte_r <= rd(bus.rx_byte[6:0]);
                                end else begin
                                    state     <= S_WRITE;
                                    tx_byte_r <= DUMMY_BYTE;
                                end
                            end
                            S_WRITE: begin
                                if (in_range(addr)) begin
                                    regs[addr[AW-1:0]] <= bus.rx_byte;
                                    wr_pulse_r         <= 1'b1;
                                    wr_addr_r          <= addr;
                                    wr_data_r          <= bus.rx_byte;
                                end else begin
                                    addr_err_r <= 1'b1;
                                end
                                addr <= addr_nxt;
                            end
                            default: begin
                                addr       <= addr_nxt;
                                tx_byte_r  <= rd(addr_nxt);
                                addr_err_r <= ~in_range(addr);
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign reg_flat[8*i +: 8] = regs[i];
    end

    assign bus.tx_byte    = tx_byte_r;
    assign bus.wr_pulse   = wr_pulse_r;
    assign bus.wr_addr    = wr_addr_r;
    assign bus.wr_data    = wr_data_r;
    assign bus.frame_done = frame_done_r;
    assign bus.addr_err   = addr_err_r;
endmodule
